// File: rtl/cu_fsm_mc_if.sv
// Control-unit bus: decoder/memory/interrupt inputs and datapath enables.
interface cu_fsm_mc_if #(
  parameter int unsigned IRQ_W = 4,
  parameter int unsigned IDW   = $clog2(IRQ_W)
);
  logic [6:0]       CU_OPCODE;
  logic [2:0]       FUNC3;
  logic             FUNC7_0;
  logic [IRQ_W-1:0] INTR;
  logic             MIE;
  logic             IMEM_READY;
  logic             DMEM_READY;

  logic             PC_WRITE;
  logic             REG_WRITE;
  logic             MEM_WRITE;
  logic             MEM_READ1;
  logic             MEM_READ2;
  logic             CSR_WR;
  logic             MUL_START;
  logic             MRET;
  logic             INT_TAKEN;
  logic             EXC_TAKEN;
  logic [IDW-1:0]   INT_ID;

  // Control unit side.
  modport master (
    input  CU_OPCODE, FUNC3, FUNC7_0, INTR, MIE, IMEM_READY, DMEM_READY,
    output PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2, CSR_WR,
    output MUL_START, MRET, INT_TAKEN, EXC_TAKEN, INT_ID
  );

  // Decoder / datapath / memory side.
  modport slave (
    output CU_OPCODE, FUNC3, FUNC7_0, INTR, MIE, IMEM_READY, DMEM_READY,
    input  PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2, CSR_WR,
    input  MUL_START, MRET, INT_TAKEN, EXC_TAKEN, INT_ID
  );
endinterface

// File: rtl/cu_fsm_mc.sv
// Multicycle RISC-V control unit: fetch/execute sequencing with memory wait
// states, MUL/DIV stall, prioritised interrupt entry and illegal-op trapping.
module cu_fsm_mc #(
  parameter int unsigned IRQ_W   = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned IDW     = $clog2(IRQ_W)
) (
  input logic         CLK,
  input logic         RST_N,
  cu_fsm_mc_if.master bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam bit          MulEn   = (MUL_LAT != 0);
  localparam int unsigned CW      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CntLoad = (MUL_LAT > 0) ? CW'(MUL_LAT - 1) : '0;

  typedef enum logic [2:0] {
    StFetch, StExecute, StLdWait, StStWait, StWb, StMul, StInterrupt, StTrap
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  int_id_q;
  logic [IDW-1:0]  irq_id;
  logic            pend, done, take_int;
  logic            pc_write, reg_write, mem_write, mem_read1, mem_read2;
  logic            csr_wr, mul_start, mret, int_taken, exc_taken;

  assign pend     = bus.MIE & (|bus.INTR);
  assign take_int = done & pend;

  // Lowest set request line wins.
  always_comb begin
    irq_id = '0;
    for (int i = int'(IRQ_W) - 1; i >= 0; i--) begin
      if (bus.INTR[i]) irq_id = IDW'(i);
    end
  end

  // State, MUL counter and interrupt-id registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StFetch;
      cnt_q    <= '0;
      int_id_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_int) int_id_q <= irq_id;
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_read1 = 1'b0;
    mem_read2 = 1'b0;
    csr_wr    = 1'b0;
    mul_start = 1'b0;
    mret      = 1'b0;
    int_taken = 1'b0;
    exc_taken = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read1 = 1'b1;
        if (bus.IMEM_READY) state_d = StExecute;
      end
      StExecute: begin
        case (bus.CU_OPCODE)
          OpLui, OpAuipc, OpJal, OpJalr, OpImm: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
            done      = 1'b1;
          end
          OpOp: begin
            if (bus.FUNC7_0 && MulEn) begin
              mul_start = 1'b1;
              cnt_d     = CntLoad;
              state_d   = StMul;
            end else begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
              done      = 1'b1;
            end
          end
          OpBranch: begin
            pc_write = 1'b1;
            done     = 1'b1;
          end
          OpLoad: begin
            mem_read2 = 1'b1;
            state_d   = bus.DMEM_READY ? StWb : StLdWait;
          end
          OpStore: begin
            mem_write = 1'b1;
            if (bus.DMEM_READY) begin
              pc_write = 1'b1;
              done     = 1'b1;
            end else begin
              state_d = StStWait;
            end
          end
          OpSystem: begin
            case (bus.FUNC3)
              3'd0: begin
                pc_write = 1'b1;
                mret     = 1'b1;
                done     = 1'b1;
              end
              3'd4: state_d = StTrap;
              default: begin
                pc_write  = 1'b1;
                reg_write = 1'b1;
                csr_wr    = 1'b1;
                done      = 1'b1;
              end
            endcase
          end
          default: state_d = StTrap;
        endcase
      end
      StLdWait: begin
        mem_read2 = 1'b1;
        if (bus.DMEM_READY) state_d = StWb;
      end
      StStWait: begin
        mem_write = 1'b1;
        if (bus.DMEM_READY) begin
          pc_write = 1'b1;
          done     = 1'b1;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        done      = 1'b1;
      end
      StMul: begin
        if (cnt_q == '0) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          done      = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StInterrupt: begin
        pc_write  = 1'b1;
        int_taken = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        pc_write  = 1'b1;
        exc_taken = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // Interrupts are only sampled at instruction boundaries.
    if (done) state_d = pend ? StInterrupt : StFetch;
  end

  // Outputs forced low while reset is asserted.
  always_comb begin
    bus.PC_WRITE  = RST_N & pc_write;
    bus.REG_WRITE = RST_N & reg_write;
    bus.MEM_WRITE = RST_N & mem_write;
    bus.MEM_READ1 = RST_N & mem_read1;
    bus.MEM_READ2 = RST_N & mem_read2;
    bus.CSR_WR    = RST_N & csr_wr;
    bus.MUL_START = RST_N & mul_start;
    bus.MRET      = RST_N & mret;
    bus.INT_TAKEN = RST_N & int_taken;
    bus.EXC_TAKEN = RST_N & exc_taken;
    bus.INT_ID    = int_id_q;
  end

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Directed bench for cu_fsm_mc: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them. A second instance
// with MUL_LAT=0 shares the inputs and is checked alongside.
module tb_cu_fsm_mc;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP  = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  // {PC_WRITE,REG_WRITE,MEM_WRITE,MEM_READ1,MEM_READ2,CSR_WR,MUL_START,MRET,INT_TAKEN,EXC_TAKEN}
  localparam logic [9:0] PCW = 10'b10_0000_0000;
  localparam logic [9:0] RGW = 10'b01_0000_0000;
  localparam logic [9:0] MW  = 10'b00_1000_0000;
  localparam logic [9:0] MR1 = 10'b00_0100_0000;
  localparam logic [9:0] MR2 = 10'b00_0010_0000;
  localparam logic [9:0] CSR = 10'b00_0001_0000;
  localparam logic [9:0] MS  = 10'b00_0000_1000;
  localparam logic [9:0] MRT = 10'b00_0000_0100;
  localparam logic [9:0] IT  = 10'b00_0000_0010;
  localparam logic [9:0] ET  = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b0;

  typedef struct {
    string      name;
    logic [9:0] o0;
    logic [9:0] o1;
    logic [1:0] id;
  } exp_t;

  logic CLK;
  logic RST_N;
  exp_t sb_q[$];
  exp_t e;
  int   n_pass;
  int   n_total;

  cu_fsm_mc_if #(.IRQ_W(4)) bus0 ();
  cu_fsm_mc_if #(.IRQ_W(4)) bus1 ();

  cu_fsm_mc #(.IRQ_W(4), .MUL_LAT(4)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(bus0));
  cu_fsm_mc #(.IRQ_W(4), .MUL_LAT(0)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));

  assign bus1.CU_OPCODE  = bus0.CU_OPCODE;
  assign bus1.FUNC3      = bus0.FUNC3;
  assign bus1.FUNC7_0    = bus0.FUNC7_0;
  assign bus1.INTR       = bus0.INTR;
  assign bus1.MIE        = bus0.MIE;
  assign bus1.IMEM_READY = bus0.IMEM_READY;
  assign bus1.DMEM_READY = bus0.DMEM_READY;

  logic [9:0] out0, out1;
  assign out0 = {bus0.PC_WRITE, bus0.REG_WRITE, bus0.MEM_WRITE, bus0.MEM_READ1, bus0.MEM_READ2,
                 bus0.CSR_WR, bus0.MUL_START, bus0.MRET, bus0.INT_TAKEN, bus0.EXC_TAKEN};
  assign out1 = {bus1.PC_WRITE, bus1.REG_WRITE, bus1.MEM_WRITE, bus1.MEM_READ1, bus1.MEM_READ2,
                 bus1.CSR_WR, bus1.MUL_START, bus1.MRET, bus1.INT_TAKEN, bus1.EXC_TAKEN};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [3:0] irq, input logic mie, input logic ir, input logic dr);
    bus0.CU_OPCODE  = opc;
    bus0.FUNC3      = f3;
    bus0.FUNC7_0    = f7;
    bus0.INTR       = irq;
    bus0.MIE        = mie;
    bus0.IMEM_READY = ir;
    bus0.DMEM_READY = dr;
  endtask

  // One cycle: record expectation for both instances, then advance.
  task automatic step2(input string nm, input logic [9:0] eo0, input logic [1:0] eid,
                       input logic [9:0] eo1);
    exp_t x;
    x.name = nm;
    x.o0   = eo0;
    x.o1   = eo1;
    x.id   = eid;
    sb_q.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string nm, input logic [9:0] eo, input logic [1:0] eid);
    step2(nm, eo, eid, eo);
  endtask

  // Monitor: outputs are combinational, sampled mid-cycle.
  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_total++;
      if (out0 === e.o0 && bus0.INT_ID === e.id) n_pass++;
      else $display("FAIL %s (lat4): out=%b id=%0d expected out=%b id=%0d",
                    e.name, out0, bus0.INT_ID, e.o0, e.id);
      n_total++;
      if (out1 === e.o1 && bus1.INT_ID === e.id) n_pass++;
      else $display("FAIL %s (lat0): out=%b id=%0d expected out=%b id=%0d",
                    e.name, out1, bus1.INT_ID, e.o1, e.id);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    RST_N   = 1'b0;
    set_in(OP_IMM, 3'd0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    step("reset0", NONE, 2'd0);
    step("reset1", NONE, 2'd0);

    // Fetch stalls on IMEM_READY, then OP_IMM.
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) step("fetch_wait", MR1, 2'd0);
    set_in(OP_IMM, 3'd0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    step("fetch_rdy", MR1, 2'd0);
    step("opimm_ex", PCW | RGW, 2'd0);

    // Load with two wait cycles.
    set_in(OP_LD, 3'd2, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    step("ld_fetch", MR1, 2'd0);
    step("ld_ex", MR2, 2'd0);
    step("ld_wait1", MR2, 2'd0);
    bus0.DMEM_READY = 1'b1;
    step("ld_wait2", MR2, 2'd0);
    step("ld_wb", PCW | RGW, 2'd0);

    // Zero-wait load.
    step("ld0_fetch", MR1, 2'd0);
    step("ld0_ex", MR2, 2'd0);
    step("ld0_wb", PCW | RGW, 2'd0);

    // Store with two wait cycles.
    set_in(OP_ST, 3'd2, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    step("st_fetch", MR1, 2'd0);
    step("st_ex", MW, 2'd0);
    step("st_wait1", MW, 2'd0);
    bus0.DMEM_READY = 1'b1;
    step("st_wait2", MW | PCW, 2'd0);

    // M-extension op: 4-cycle stall at MUL_LAT=4, single cycle at MUL_LAT=0.
    set_in(OP_OP, 3'd0, 1'b1, 4'b0, 1'b0, 1'b1, 1'b0);
    step("mul_fetch", MR1, 2'd0);
    bus0.IMEM_READY = 1'b0;
    step2("mul_ex", MS, 2'd0, PCW | RGW);
    for (int i = 0; i < 3; i++) step2("mul_busy", NONE, 2'd0, MR1);
    step2("mul_done", PCW | RGW, 2'd0, MR1);
    bus0.FUNC7_0 = 1'b0;
    bus0.IMEM_READY = 1'b1;
    step("op_fetch", MR1, 2'd0);
    step("op_ex", PCW | RGW, 2'd0);

    // Branch completes with pending interrupts 1010 -> id 1.
    set_in(OP_BR, 3'd0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    step("br_fetch", MR1, 2'd0);
    bus0.INTR = 4'b1010;
    bus0.MIE  = 1'b1;
    step("br_ex", PCW, 2'd0);
    step("irq_entry", PCW | IT, 2'd1);
    bus0.INTR = 4'b0;
    bus0.MIE  = 1'b0;
    step("post_irq_fetch", MR1, 2'd1);
    // Same with MIE=0: back to fetch.
    bus0.INTR = 4'b1010;
    step("br2_ex", PCW, 2'd1);
    step("br2_fetch", MR1, 2'd1);

    // Zero-wait store with pending interrupt: completes, then interrupt (id 2).
    // FETCH itself must not take the interrupt.
    set_in(OP_ST, 3'd2, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1);
    step("st0_ex", MW | PCW, 2'd1);
    step("st0_irq", PCW | IT, 2'd2);
    set_in(OP_IMM, 3'd0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
    step("oi_fetch", MR1, 2'd2);
    step("oi_ex", PCW | RGW, 2'd2);
    step("oi_irq", PCW | IT, 2'd3);

    // Illegal opcode traps with MIE=0.
    set_in(7'b0000000, 3'd0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0);
    step("ill_fetch", MR1, 2'd3);
    step("ill_ex", NONE, 2'd3);
    step("ill_trap", PCW | ET, 2'd3);
    // SYSTEM funct3=4 traps; TRAP returns to FETCH even with interrupts pending.
    set_in(OP_SYS, 3'd4, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
    step("sys4_fetch", MR1, 2'd3);
    step("sys4_ex", NONE, 2'd3);
    step("sys4_trap", PCW | ET, 2'd3);

    // CSR access and MRET.
    set_in(OP_SYS, 3'd2, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    step("csr_fetch", MR1, 2'd3);
    step("csr_ex", PCW | RGW | CSR, 2'd3);
    bus0.FUNC3 = 3'd0;
    step("mret_fetch", MR1, 2'd3);
    step("mret_ex", PCW | MRT, 2'd3);

    // Reset in the middle of a load wait.
    set_in(OP_LD, 3'd2, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    step("rl_fetch", MR1, 2'd3);
    step("rl_ex", MR2, 2'd3);
    step("rl_wait", MR2, 2'd3);
    RST_N = 1'b0;
    set_in(OP_LD, 3'd2, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    step("rst_mid", NONE, 2'd0);
    step("rst_hold", NONE, 2'd0);
    RST_N = 1'b1;
    set_in(OP_LD, 3'd2, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    step("rst_rel", MR1, 2'd0);
    step("rst_rel2", MR1, 2'd0);

    for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
